route_dispatch: RTL and testbench
=================================

# route_dispatch

Registered dispatch stage that sits directly downstream of the combinational router. Each cycle it accepts one 60-bit word pair together with the router's 3-bit route code (y0..y2). It buffers the word into one per-destination FIFO for each set bit of the code, then presents it on up to three output channels with valid/ready handshakes. Words with an all-zero route code are dropped and counted.

## Interface
Parameters:
- DATA_W, 60, width of the routed word (the router's x0..x59 operand pair)
- NDEST, 3, number of destinations; one per route-code bit
- DEPTH, 4, entries per destination FIFO; must be a power of two, ≥2
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  word and route code valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  word to forward
- in_route  in  NDEST  router output; bit i set = send to destination i
- out_valid  out  NDEST  per-destination valid
- out_ready  in  NDEST  per-destination ready
- out_data  out  NDEST*DATA_W  destination i occupies bits [i*DATA_W +: DATA_W]
- drop_cnt  out  CNT_W  count of words dropped for a zero route
- acc_cnt  out  CNT_W  count of accepted words, including dropped ones

## Operation
- Accept condition: in_valid & in_ready. in_ready = AND over i of (!in_route[i] | !full[i]).
- Multicast is all-or-nothing. A word is never partially written.
- in_ready depends only on in_route and the registered FIFO full flags. It never depends on out_ready, so a full FIFO refuses input even when it is popped in the same cycle.
- On accept with in_route != 0: push in_data into every FIFO i with in_route[i]=1.
- On accept with in_route == 0: no push; drop_cnt increments. in_ready is 1 for a zero route.
- Each FIFO is independent. Pop happens on out_valid[i] & out_ready[i]. out_valid[i] = !empty[i]. out_data[i] = head entry; it is held stable while valid and not popped.
- Simultaneous push and pop on the same non-full, non-empty FIFO: occupancy is unchanged and order is preserved.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset (async assert, at any time including mid-transfer): all FIFOs empty, pointers 0, out_valid=0, counters 0, in_ready reflects empty FIFOs. FIFO storage contents are not reset. out_data is don't-care while out_valid=0.

## Timing
- Latency: a word accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: one word per cycle per FIFO while it is not full. Occupancy reaches DEPTH when a destination stalls.
- Output side: out_valid never drops without a pop.
- Input side: in_ready may drop while in_valid is held; the upstream must hold in_data and in_route stable until accept.
- No combinational path from out_ready to in_ready, nor from in_* to out_*.

## Configuration
- ROUTE_DISPATCH_STATS_EN defined: drop_cnt and acc_cnt are live as described above.
- ROUTE_DISPATCH_STATS_EN not defined: both counter registers are removed, both ports are tied to 0, and zero-route words are still accepted and discarded.

## Structure
- Package route_pkg holds:
  - NDEST_C = 3
  - typedef route_t (logic [NDEST_C-1:0])
  - typedef word_t (logic [59:0])
  - function is_drop(route_t)
- Sub-module dispatch_fifo: a single-clock FIFO (parameters DATA_W, DEPTH) with push, pop, full, empty and head-data ports. route_dispatch instantiates NDEST of them in a generate loop and adds the accept logic and counters.

## Test plan
- Unicast: send route 3'b010 with data 60'h123, all out_ready=1. Expect out_valid=3'b010 the next cycle with out_data[1]=60'h123, and acc_cnt=1.
- Multicast all-or-nothing: hold out_ready[0]=0 and fill FIFO0 with 4 words of route 3'b001. Then send route 3'b011 → in_ready=0, and FIFO1 stays empty. Pop one from FIFO0 → the word is accepted into both FIFO0 and FIFO1 the following cycle.
- Drop: send 5 words with route 3'b000 → in_ready stays 1, no out_valid, drop_cnt=5, acc_cnt=5. With the macro undefined, both counters read 0.
- Full with simultaneous pop: fill FIFO2 to 4 entries, then assert out_ready[2]=1 and in_valid with route 3'b100 in the same cycle. Expect in_ready=0 that cycle, occupancy 3 afterwards, and the word accepted on the next cycle.
- Ordering and wrap: stream 20 words 0..19 to destination 0 with out_ready toggling 1,0,1,0. Expect the output sequence 0..19 exactly, with no duplicates or losses.
- Reset mid-operation: with 3 words queued in FIFO1, assert rst_n=0 between clock edges. Expect out_valid=0 and counters 0 immediately. After release, the first new word is accepted and appears after one cycle.

Source files
------------

// File: rtl/route_pkg.sv
// Shared types and constants for the route dispatch stage.
package route_pkg;

  localparam int NDEST_C  = 3;
  localparam int WORD_W_C = 60;

  typedef logic [NDEST_C-1:0]  route_t;
  typedef logic [WORD_W_C-1:0] word_t;

  // A word whose route code selects no destination is discarded.
  function automatic logic is_drop(input route_t route);
    return (route == '0);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is presented
// combinationally from the storage array.
module dispatch_fifo #(
  parameter int DATA_W = 60,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/route_dispatch.sv
// Dispatch stage: fans a routed word out to per-destination FIFOs.
// Statistics counters exist only when ROUTE_DISPATCH_STATS_EN is defined.
module route_dispatch
  import route_pkg::*;
#(
  parameter int DATA_W = WORD_W_C,
  parameter int NDEST  = NDEST_C,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [NDEST-1:0]        in_route,
  output logic [NDEST-1:0]        out_valid,
  input  logic [NDEST-1:0]        out_ready,
  output logic [NDEST*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        acc_cnt
);

  logic [NDEST-1:0]  w_full;
  logic [NDEST-1:0]  w_empty;
  logic [NDEST-1:0]  w_push;
  logic [NDEST-1:0]  w_pop;
  logic [DATA_W-1:0] w_head [NDEST];
  logic              w_in_ready;
  logic              w_accept;

  // Uses only registered full flags, so out_ready never reaches in_ready.
  assign w_in_ready = &(~in_route | ~w_full);
  assign w_accept   = in_valid & w_in_ready;
  assign in_ready   = w_in_ready;
  assign out_valid  = ~w_empty;
  assign w_pop      = out_valid & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NDEST; gi++) begin : g_dest
      assign w_push[gi] = w_accept & in_route[gi];

      dispatch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push[gi]),
        .i_pop   (w_pop[gi]),
        .i_data  (in_data),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_head  (w_head[gi])
      );

      assign out_data[gi*DATA_W +: DATA_W] = w_head[gi];
    end
  endgenerate

`ifdef ROUTE_DISPATCH_STATS_EN
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_acc_cnt;

  assign w_drop = (NDEST == NDEST_C) ? is_drop(route_t'(in_route)) : ~|in_route;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_acc_cnt  <= '0;
    end else if (w_accept) begin
      if (r_acc_cnt != '1) begin
        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign acc_cnt  = r_acc_cnt;
`else
  assign drop_cnt = '0;
  assign acc_cnt  = '0;
`endif

endmodule

// File: tb/tb_route_dispatch.sv
// Scoreboard bench for route_dispatch: per-destination expected queues are
// filled on modelled accepts and drained on handshakes.
module tb_route_dispatch;

  localparam int DW = 60;
  localparam int ND = 3;
  localparam int DP = 4;
  localparam int CW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [ND-1:0]   in_route;
  logic [ND-1:0]   out_valid;
  logic [ND-1:0]   out_ready;
  logic [ND*DW-1:0] out_data;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   acc_cnt;

  route_dispatch #(
    .DATA_W (DW),
    .NDEST  (ND),
    .DEPTH  (DP),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_route  (in_route),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int m_acc  = 0;
  int m_drop = 0;
  int n_popped [ND];

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void q_push(input int i, input logic [DW-1:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  function automatic logic [DW-1:0] q_pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    m_acc  = 0;
    m_drop = 0;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int v);
`ifdef ROUTE_DISPATCH_STATS_EN
    return CW'(v);
`else
    return (v == 0) ? CW'(0) : CW'(0);
`endif
  endfunction

  // One clock of stimulus; scoreboard compares every handshake output.
  task automatic step(input logic v, input logic [ND-1:0] r,
                      input logic [DW-1:0] d, input logic [ND-1:0] rdy,
                      output logic acc);
    logic exp_rdy;
    logic [DW-1:0] exp_d;
    in_valid  = v;
    in_route  = r;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
    exp_rdy = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (r[i] && q_size(i) >= DP) exp_rdy = 1'b0;
    end
    n_tests++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready route=%b got=%b exp=%b", r, in_ready, exp_rdy);
    end
    for (int i = 0; i < ND; i++) begin
      n_tests++;
      if (out_valid[i] !== (q_size(i) != 0)) begin
        n_fail++;
        $display("FAIL out_valid[%0d] got=%b exp=%b", i, out_valid[i], q_size(i) != 0);
      end
      if (q_size(i) != 0 && rdy[i]) begin
        exp_d = q_pop(i);
        n_popped[i]++;
        n_tests++;
        if (out_data[i*DW +: DW] !== exp_d) begin
          n_fail++;
          $display("FAIL out_data[%0d] got=%h exp=%h", i, out_data[i*DW +: DW], exp_d);
        end
      end
    end
    acc = v & exp_rdy;
    if (acc) begin
      m_acc++;
      if (r == '0) m_drop++;
      for (int i = 0; i < ND; i++) if (r[i]) q_push(i, d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 20 && (q0.size() + q1.size() + q2.size()) != 0; c++) begin
      step(1'b0, '0, '0, '1, acc);
    end
    n_tests++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL drain out_valid got=%b exp=000", out_valid);
    end
  endtask

  task automatic check_counters(input string name);
    n_tests++;
    if (acc_cnt !== exp_cnt(m_acc)) begin
      n_fail++;
      $display("FAIL %s acc_cnt got=%0d exp=%0d", name, acc_cnt, exp_cnt(m_acc));
    end
    n_tests++;
    if (drop_cnt !== exp_cnt(m_drop)) begin
      n_fail++;
      $display("FAIL %s drop_cnt got=%0d exp=%0d", name, drop_cnt, exp_cnt(m_drop));
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_route  = 3'b111;
    in_data   = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset out_valid=%b in_ready=%b exp 000/1", out_valid, in_ready);
    end
    check_counters("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset done");
  endtask

  task automatic test_unicast();
    logic acc;
    step(1'b1, 3'b010, 60'h123, 3'b111, acc);
    n_tests++;
    if (out_valid !== 3'b010 || out_data[DW +: DW] !== 60'h123) begin
      n_fail++;
      $display("FAIL unicast out_valid=%b data=%h exp 010/123", out_valid, out_data[DW +: DW]);
    end
    check_counters("unicast");
    drain();
    $display("[TB] unicast route=010 data=123 acc=%b", acc);
  endtask

  task automatic test_multicast();
    logic acc;
    for (int i = 0; i < DP; i++) step(1'b1, 3'b001, 60'(16'hA000 + i), 3'b000, acc);
    in_valid = 1'b1;
    in_route = 3'b011;
    in_data  = 60'hBEEF;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 3'b001) begin
      n_fail++;
      $display("FAIL multicast_block in_ready=%b out_valid=%b exp 0/001", in_ready, out_valid);
    end
    step(1'b1, 3'b011, 60'hBEEF, 3'b001, acc);
    n_tests++;
    if (acc !== 1'b0 || out_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL multicast_partial out_valid[1]=%b exp 0", out_valid[1]);
    end
    step(1'b1, 3'b011, 60'hBEEF, 3'b000, acc);
    n_tests++;
    if (acc !== 1'b1 || out_valid !== 3'b011) begin
      n_fail++;
      $display("FAIL multicast_accept out_valid=%b exp 011", out_valid);
    end
    drain();
    $display("[TB] multicast route=011 accepted after pop");
  endtask

  task automatic test_drop();
    logic acc;
    for (int i = 0; i < 5; i++) step(1'b1, 3'b000, 60'(i), 3'b111, acc);
    step(1'b0, '0, '0, 3'b111, acc);
    n_tests++;
    if (m_drop < 5 || out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL drop out_valid=%b exp 000 drops=%0d", out_valid, m_drop);
    end
    check_counters("drop");
    $display("[TB] drop 5 words drop_cnt=%0d acc_cnt=%0d", drop_cnt, acc_cnt);
  endtask

  task automatic test_full_pop();
    logic acc;
    for (int i = 0; i < DP; i++) step(1'b1, 3'b100, 60'(16'hC000 + i), 3'b000, acc);
    step(1'b1, 3'b100, 60'hC0DE, 3'b100, acc);
    n_tests++;
    if (acc !== 1'b0 || q2.size() != 3 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop in_ready=%b exp 1 occ=%0d", in_ready, q2.size());
    end
    step(1'b1, 3'b100, 60'hC0DE, 3'b000, acc);
    n_tests++;
    if (acc !== 1'b1 || out_valid[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_accept out_valid[2]=%b exp 1", out_valid[2]);
    end
    drain();
    $display("[TB] full with pop: accepted one cycle later");
  endtask

  task automatic test_order_wrap();
    logic acc;
    int idx = 0;
    n_popped[0] = 0;
    for (int c = 0; c < 200 && idx < 20; c++) begin
      step(1'b1, 3'b001, 60'(idx), {2'b00, ~c[0]}, acc);
      if (acc) idx++;
    end
    drain();
    n_tests++;
    if (idx != 20 || n_popped[0] != 20) begin
      n_fail++;
      $display("FAIL order sent=%0d popped=%0d exp 20", idx, n_popped[0]);
    end
    $display("[TB] ordering stream sent=%0d popped=%0d", idx, n_popped[0]);
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010, 60'(16'hD000 + i), 3'b000, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid out_valid=%b in_ready=%b exp 000/1", out_valid, in_ready);
    end
    check_counters("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 3'b010, 60'h5A5, 3'b000, acc);
    n_tests++;
    if (out_valid !== 3'b010 || out_data[DW +: DW] !== 60'h5A5) begin
      n_fail++;
      $display("FAIL reset_mid_first out_valid=%b data=%h exp 010/5a5", out_valid, out_data[DW +: DW]);
    end
    drain();
    check_counters("reset_mid_after");
    $display("[TB] reset mid-operation, first new word ok");
  endtask

  initial begin
    for (int i = 0; i < ND; i++) n_popped[i] = 0;
    test_reset();
    test_unicast();
    test_multicast();
    test_drop();
    test_full_pop();
    test_order_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
